// File: rtl/rom_addr_sequencer.sv
// Command sequencer for the ROM/mux/ALU concatenation datapath: buffers address bundles,
// drives the ROM address buses, waits SETTLE cycles and captures the result. Option: ROMSEQ_COUNT_EN.
module rom_addr_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [15:0]                   cmd_data,
  output logic [4:0]                    addr_rom1,
  output logic [1:0]                    addr_rom2,
  output logic [1:0]                    addr_rom3,
  output logic [1:0]                    addr_rom4,
  output logic [1:0]                    addr_rom5,
  output logic [2:0]                    addr_rom6,
  input  logic [31:0]                   cat_result,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [31:0]                   res_data,
`ifdef ROMSEQ_COUNT_EN
  output logic [15:0]                   done_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // state | meaning
  // IDLE  | no bundle in flight; pops (loads) the FIFO head when one is available
  // WAIT  | addresses driven, settle counter running down to zero
  // HOLD  | result captured, res_valid high until downstream accepts
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] SETTLE_TOP = CW'(SETTLE - 1);

  state_t        state, state_nxt;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] settle_cnt;
  logic          full, empty, push, pop, capture, accept;
  logic [15:0]   head;

  assign full      = (fifo_count == FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          accept = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cmd_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_rom1  <= '0;
      addr_rom2  <= '0;
      addr_rom3  <= '0;
      addr_rom4  <= '0;
      addr_rom5  <= '0;
      addr_rom6  <= '0;
      settle_cnt <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      if (pop) begin
        addr_rom1  <= head[15:11];
        addr_rom2  <= head[10:9];
        addr_rom3  <= head[8:7];
        addr_rom4  <= head[6:5];
        addr_rom5  <= head[4:3];
        addr_rom6  <= head[2:0];
        settle_cnt <= SETTLE_TOP;
      end else if (state == WAIT && !capture) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (capture) begin
        res_data  <= cat_result;
        res_valid <= 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ROMSEQ_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)         done_count <= '0;
    else if (accept) done_count <= done_count + 1'b1;
  end
`endif

endmodule
